// File: rtl/io_pkg.sv
// Shared types and helpers for the console IO bus arbiter.
package io_pkg;

    localparam int CON_W     = 2;
    localparam int NCON      = 4;
    localparam int IO_ADDR_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_ACK
    } state_t;

    // The console index becomes address[17:16], so each console sees its own register bank.
    function automatic logic [IO_ADDR_W-1:0] con_bank_addr(input logic [CON_W-1:0] idx,
                                                           input logic [15:0]      addr16);
        return {1'b0, idx, addr16};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate-priority picker: first set req at or after base, with an
// optional override index that wins whenever its request is set.
module rr_pick4
    import io_pkg::*;
(
    input  logic [NCON-1:0]  req,
    input  logic [CON_W-1:0] base,
    input  logic             mask_en,
    input  logic [CON_W-1:0] mask_idx,
    output logic             valid,
    output logic [CON_W-1:0] idx
);

    logic             found;
    logic [CON_W-1:0] cand;

    always_comb begin
        valid = |req;
        idx   = base;
        found = 1'b0;
        cand  = base;
        for (int k = 0; k < NCON; k++) begin
            cand = base + k[CON_W-1:0];
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        if (mask_en && req[mask_idx]) begin
            idx = mask_idx;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO subsystem between four consoles, plus the
// visible/active console registers. Define IOARB_ACTIVE_PRIO_EN to give the active console priority.
module io_bus_arbiter
    import io_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_we,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [7:0]           rdata,
    output logic [IO_ADDR_W-1:0] io_address,
    output logic [7:0]           io_din,
    output logic                 io_we,
    input  logic [7:0]           io_dout,
    input  logic                 console_next,
    input  logic                 console_take,
    output logic [CON_W-1:0]     visible,
    output logic [CON_W-1:0]     active
);

    state_t               state_q;
    logic [CON_W-1:0]     rr_q;
    logic [CON_W-1:0]     idx_q;
    logic                 prio_q;
    logic [NREQ-1:0]      ack_q;
    logic [7:0]           rdata_q;
    logic [IO_ADDR_W-1:0] io_address_q;
    logic [7:0]           io_din_q;
    logic                 io_we_q;
    logic [CON_W-1:0]     visible_q;
    logic [CON_W-1:0]     active_q;

    logic                 prio_en;
    logic                 prio_hit;
    logic                 pick_vld;
    logic [CON_W-1:0]     pick_idx;

`ifdef IOARB_ACTIVE_PRIO_EN
    assign prio_en = 1'b1;
`else
    assign prio_en = 1'b0;
`endif

    // A priority grant leaves rr untouched so the others keep their rotation.
    assign prio_hit = prio_en & req[active_q];

    rr_pick4 u_pick (
        .req      (req),
        .base     (rr_q),
        .mask_en  (prio_en),
        .mask_idx (active_q),
        .valid    (pick_vld),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            idx_q        <= '0;
            prio_q       <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            io_address_q <= '0;
            io_din_q     <= '0;
            io_we_q      <= 1'b0;
        end else begin
            ack_q   <= '0;
            io_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        idx_q        <= pick_idx;
                        prio_q       <= prio_hit;
                        io_address_q <= con_bank_addr(pick_idx, req_addr[{pick_idx, 4'b0000} +: 16]);
                        io_din_q     <= req_wdata[{pick_idx, 3'b000} +: 8];
                        io_we_q      <= req_we[pick_idx];
                        state_q      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    rdata_q      <= io_dout;
                    ack_q[idx_q] <= 1'b1;
                    state_q      <= ST_ACK;
                end
                ST_ACK: begin
                    if (!prio_q) begin
                        rr_q <= idx_q + 2'd1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Take samples the pre-increment visible when both pulses coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            visible_q <= '0;
            active_q  <= '0;
        end else begin
            if (console_take) begin
                active_q <= visible_q;
            end
            if (console_next) begin
                visible_q <= visible_q + 2'd1;
            end
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign io_address = io_address_q;
    assign io_din     = io_din_q;
    assign io_we      = io_we_q;
    assign visible    = visible_q;
    assign active     = active_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter with a transaction-level reference model.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic [18:0] io_address;
    logic [7:0]  io_din;
    logic        io_we;
    logic [7:0]  io_dout;
    logic        console_next;
    logic        console_take;
    logic [1:0]  visible;
    logic [1:0]  active;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // Reference model: the grant edge number fixes when io_we and ack appear.
    int          m_cyc, m_g, m_idx;
    logic [1:0]  m_rr, m_vis, m_act;
    logic        m_we;
    logic [18:0] m_addr;
    logic [7:0]  m_din, m_rdata;
    bit          prio_build;

    io_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata),
        .io_address   (io_address),
        .io_din       (io_din),
        .io_we        (io_we),
        .io_dout      (io_dout),
        .console_next (console_next),
        .console_take (console_take),
        .visible      (visible),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cyc = 0; m_g = -100; m_idx = 0;
        m_rr = 2'd0; m_vis = 2'd0; m_act = 2'd0;
        m_we = 1'b0; m_addr = '0; m_din = '0; m_rdata = '0;
    endtask

    task automatic model_edge();
        int w;
        bit pr;
        logic [1:0] nv, na;
        m_cyc++;
        nv = console_next ? m_vis + 2'd1 : m_vis;
        na = console_take ? m_vis : m_act;
        if (m_cyc == m_g + 1) m_rdata = io_dout;
        if (m_cyc >= m_g + 3 && req != 4'd0) begin
            w = -1;
            pr = 1'b0;
            if (prio_build && req[m_act]) begin
                w = int'(m_act);
                pr = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (int'(m_rr) + k) % 4;
                if (w < 0 && req[j]) w = j;
            end
            m_g    = m_cyc;
            m_idx  = w;
            m_we   = req_we[w];
            m_addr = {1'b0, w[1:0], req_addr[16*w +: 16]};
            m_din  = req_wdata[8*w +: 8];
            if (!pr) m_rr = 2'((w + 1) % 4);
        end
        m_vis = nv;
        m_act = na;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("ack",        32'(ack),        (m_cyc == m_g + 1) ? 32'(4'b0001 << m_idx) : 32'd0);
            chk("io_we",      32'(io_we),      (m_cyc == m_g) ? 32'(m_we) : 32'd0);
            chk("io_address", 32'(io_address), 32'(m_addr));
            chk("io_din",     32'(io_din),     32'(m_din));
            chk("rdata",      32'(rdata),      32'(m_rdata));
            chk("visible",    32'(visible),    32'(m_vis));
            chk("active",     32'(active),     32'(m_act));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, got;
        bit [3:0] pend;
`ifdef IOARB_ACTIVE_PRIO_EN
        prio_build = 1'b1;
`else
        prio_build = 1'b0;
`endif
        reset = 1'b1; req = '0; req_addr = '0; req_we = '0; req_wdata = '0;
        io_dout = '0; console_next = 1'b0; console_take = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        run = 1'b1;

        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_io_we", 32'(io_we), 32'd0);
        chk("rst_io_address", 32'(io_address), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_visible", 32'(visible), 32'd0);
        chk("rst_active", 32'(active), 32'd0);

        // All four requesting from reset.
        req = 4'hF;
        n = 0; last = 0;
        for (int c = 0; c < 60 && n < 12; c++) begin
            step();
            if (ack != 4'd0) begin
                got = onehot_idx(ack);
                chk("fair_order", 32'(got), prio_build ? 32'd0 : 32'(n % 4));
                if (n > 0) chk("fair_gap", 32'(c - last), 32'd3);
                last = c;
                n++;
                if (n == 12) req = 4'h0;
            end
        end
        chk("fair_count", 32'(n), 32'd12);
        req = 4'h0;
        repeat (3) step();

        // Make console 3 active, then everyone requests.
        for (int i = 0; i < 3; i++) begin
            console_next = 1'b1; step(); console_next = 1'b0;
        end
        console_take = 1'b1; step(); console_take = 1'b0;
        chk("prio_active", 32'(active), 32'd3);
        req = 4'hF;
        n = 0;
        for (int c = 0; c < 60 && n < 12; c++) begin
            step();
            if (ack != 4'd0) begin
                got = onehot_idx(ack);
                chk("prio_order", 32'(got), prio_build ? 32'd3 : 32'(n % 4));
                n++;
                if (n == 12) req = 4'h0;
            end
        end
        chk("prio_count", 32'(n), 32'd12);
        req = 4'h0;
        repeat (3) step();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            console_next = 1'b1; step(); console_next = 1'b0;
        end
        chk("next_x5", 32'(visible), 32'd1);
        console_next = 1'b1; console_take = 1'b1; step();
        console_next = 1'b0; console_take = 1'b0;
        chk("take_active", 32'(active), 32'd1);
        chk("take_visible", 32'(visible), 32'd2);

        // Single write from console 2.
        req = 4'b0100; req_addr[47:32] = 16'hB000; req_we = 4'b0100; req_wdata[23:16] = 8'h5A;
        step();
        chk("wr_address", 32'(io_address), 32'h2B000);
        chk("wr_io_we", 32'(io_we), 32'd1);
        chk("wr_io_din", 32'(io_din), 32'h5A);
        step();
        chk("wr_io_we_drop", 32'(io_we), 32'd0);
        chk("wr_ack", 32'(ack), 32'b0100);
        req = 4'h0; req_we = 4'h0;
        step();
        chk("wr_ack_drop", 32'(ack), 32'd0);

        // Read from console 1.
        req = 4'b0010; req_addr[31:16] = 16'hB001;
        step();
        io_dout = 8'hC3;
        chk("rd_address", 32'(io_address), 32'h1B001);
        chk("rd_io_we", 32'(io_we), 32'd0);
        step();
        chk("rd_ack", 32'(ack), 32'b0010);
        chk("rd_rdata", 32'(rdata), 32'hC3);
        req = 4'h0; io_dout = 8'h00;
        step();

        // Reset in the middle of a write transfer.
        req = 4'b1000; req_we = 4'b1000; req_addr[63:48] = 16'hB123;
        step();
        chk("mid_io_we", 32'(io_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_io_we", 32'(io_we), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_visible", 32'(visible), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        model_clear();
        req = 4'hF; req_we = 4'h0;
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        step();
        chk("post_rst_grant", 32'(ack), 32'b0001);
        req = 4'h0;
        repeat (3) step();

        // Randomized traffic.
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            if (m_cyc == m_g + 1) pend[m_idx] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        req[i] = 1'b1;
                        req_we[i] = 1'($urandom_range(0, 1));
                        req_addr[16*i +: 16] = 16'($urandom);
                        req_wdata[8*i +: 8] = 8'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            console_next = ($urandom_range(0, 7) == 0);
            console_take = ($urandom_range(0, 7) == 0);
            io_dout = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
